// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the CPU/debug memory arbiter
// State encoding, port IDs (CPU=0, DBG=1) and default memory geometry.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GNT_CPU = 2'd1;
    localparam logic [1:0] ST_GNT_DBG = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/arb2_rr.sv
// rtl/arb2_rr.sv - two-requester tie-break, one-hot grant (bit0=CPU, bit1=DBG)
// Macro MEM_ARB_DBG_PRIO_EN: debug always wins ties; otherwise the port not granted last wins.
module arb2_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef MEM_ARB_DBG_PRIO_EN
                grant = 2'b10;
`else
                grant = (last == PORT_DBG) ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates CPU and debug loader onto one single-port memory
// Macro MEM_ARB_DBG_PRIO_EN (in arb2_rr) switches round-robin ties to fixed debug priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              cpu_rvalid_q, dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic [1:0]        grant;
    logic              cpu_access, dbg_access;

    arb2_rr u_arb2_rr (
        .req   ({dbg_req, cpu_req}),
        .last  (last_gnt_q),
        .grant (grant)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant[0]) begin
                    state_d    = ST_GNT_CPU;
                    last_gnt_d = PORT_CPU;
                end else if (grant[1]) begin
                    state_d    = ST_GNT_DBG;
                    last_gnt_d = PORT_DBG;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A grant only performs an access if the requester is still asking and reset is low.
    assign cpu_access = (state_q == ST_GNT_CPU) && cpu_req && !rst;
    assign dbg_access = (state_q == ST_GNT_DBG) && dbg_req && !rst;

    assign cpu_gnt    = cpu_access;
    assign dbg_gnt    = dbg_access;
    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_access) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dbg_access) begin
            mem_addr  = dbg_addr;
            mem_we    = dbg_we;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= PORT_DBG;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            cpu_rvalid_q <= cpu_access & ~cpu_we;
            dbg_rvalid_q <= dbg_access & ~dbg_we;
            if (cpu_access && !cpu_we) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dbg_access && !dbg_we) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (honours MEM_ARB_DBG_PRIO_EN)
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [64];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    int          cpu_gq[$];
    int          dbg_gq[$];
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];

    mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: every grant and every read return is matched against the expected queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_gnt) begin
                if (cpu_gq.size() == 0) unexpected("cpu_gnt");
                else chk("cpu_gnt_cycle", cyc, cpu_gq.pop_front());
            end
            if (dbg_gnt) begin
                if (dbg_gq.size() == 0) unexpected("dbg_gnt");
                else chk("dbg_gnt_cycle", cyc, dbg_gq.pop_front());
            end
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) unexpected("cpu_rvalid");
                else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
            if (dbg_rvalid) begin
                if (dbg_q.size() == 0) unexpected("dbg_rvalid");
                else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
        end
    end

    // One access: request at cycle n, expect grant at n+lat, drop request the cycle after grant.
    task automatic access(input logic port, input logic we, input logic [5:0] a,
                          input logic [31:0] d, input int lat, input logic [31:0] exp_d);
        bit got;
        @(posedge clk); #1;
        got = 0;
        if (port == PORT_CPU) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
            cpu_gq.push_back(cyc + lat);
            if (!we) cpu_q.push_back(exp_d);
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
            dbg_gq.push_back(cyc + lat);
            if (!we) dbg_q.push_back(exp_d);
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = (port == PORT_CPU) ? cpu_gnt : dbg_gnt;
        end
        if (!got) unexpected(port == PORT_CPU ? "cpu_gnt_timeout" : "dbg_gnt_timeout");
        @(posedge clk); #1;
        if (port == PORT_CPU) cpu_req = 1'b0;
        else dbg_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        for (int i = 0; i < 64; i++) mem[i] = i;
        mem[5]  = 32'hDEADBEEF;
        mem[10] = 32'hA5A5_0010;
        mem[20] = 32'h5A5A_0020;

        do_reset();
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_stall", cpu_stall, 0);

        // Both ports held after reset: alternate grants, or debug every time with fixed priority.
        @(posedge clk); #1;
        n = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10;
        dbg_req = 1; dbg_we = 0; dbg_addr = 20;
`ifdef MEM_ARB_DBG_PRIO_EN
        for (int k = 1; k <= 7; k += 2) begin
            dbg_gq.push_back(n + k);
            dbg_q.push_back(32'h5A5A_0020);
        end
`else
        cpu_gq.push_back(n + 1); cpu_q.push_back(32'hA5A5_0010);
        dbg_gq.push_back(n + 3); dbg_q.push_back(32'h5A5A_0020);
        cpu_gq.push_back(n + 5); cpu_q.push_back(32'hA5A5_0010);
        dbg_gq.push_back(n + 7); dbg_q.push_back(32'h5A5A_0020);
`endif
        repeat (8) @(posedge clk);
        #1;
        cpu_req = 0; dbg_req = 0;
        repeat (2) @(posedge clk);

        access(PORT_CPU, 0, 5, 0, 1, 32'hDEADBEEF);
        access(PORT_DBG, 1, 3, 32'h12345678, 1, 0);
        access(PORT_CPU, 0, 3, 0, 1, 32'h12345678);
        access(PORT_CPU, 1, 7, 32'hCAFEF00D, 1, 0);
        chk("cpu_rdata_hold", cpu_rdata, 32'h12345678);
        access(PORT_DBG, 0, 7, 0, 1, 32'hCAFEF00D);

        // Stall: debug was granted last only on tie rules; last grant here was DBG, so CPU wins.
        // Force debug first by letting CPU go last.
        access(PORT_CPU, 0, 5, 0, 1, 32'hDEADBEEF);
        fork
            access(PORT_DBG, 0, 3, 0, 1, 32'h12345678);
            access(PORT_CPU, 0, 7, 0, 3, 32'hCAFEF00D);
            begin
                @(posedge clk); #1;
                @(posedge clk); #2;
                chk("stall_dbg_gnt", dbg_gnt, 1);
                chk("stall_during_dbg", cpu_stall, 1);
                @(posedge clk); #2;
                chk("stall_idle_gap", cpu_stall, 1);
                @(posedge clk); #2;
                chk("stall_cpu_gnt", cpu_gnt, 1);
                chk("stall_released", cpu_stall, 0);
            end
        join

        // Debug request pulsed only while CPU is granted: must be ignored.
        fork
            access(PORT_CPU, 0, 5, 0, 1, 32'hDEADBEEF);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                dbg_req = 1; dbg_we = 0; dbg_addr = 4;
                @(posedge clk); #1;
                dbg_req = 0;
            end
        join
        repeat (3) @(posedge clk);

        // Reset during a CPU read grant.
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("rst_mid_read_mem_we", mem_we, 0);
        chk("rst_mid_read_cpu_gnt", cpu_gnt, 0);
        @(posedge clk); #1;
        rst = 0; cpu_req = 0;
        chk("rst_mid_read_state", dut.state_q, ST_IDLE);
        chk("rst_mid_read_rvalid", cpu_rvalid, 0);
        repeat (2) @(posedge clk);

        // Reset during a debug write grant: the write must not land.
        @(posedge clk); #1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 9; dbg_wdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("rst_mid_write_mem_we", mem_we, 0);
        chk("rst_mid_write_dbg_gnt", dbg_gnt, 0);
        @(posedge clk); #1;
        rst = 0; dbg_req = 0; dbg_we = 0;
        repeat (2) @(posedge clk);
        access(PORT_CPU, 0, 9, 0, 1, 32'h0000_0009);

        for (int i = 0; i < 10; i++) begin
            if (cpu_q.size() == 0 && dbg_q.size() == 0 && cpu_gq.size() == 0 && dbg_gq.size() == 0)
                break;
            @(posedge clk);
        end
        @(negedge clk);
        chk("cpu_gnt_queue_empty", cpu_gq.size(), 0);
        chk("dbg_gnt_queue_empty", dbg_gq.size(), 0);
        chk("cpu_data_queue_empty", cpu_q.size(), 0);
        chk("dbg_data_queue_empty", dbg_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word address width of the unified instruction/data memory.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req/cpu_we  input  1 each  CPU access request / write qualifier.
REQ-006 SHALL have ports cpu_addr  input  ADDR_W  and  cpu_wdata  input  DATA_W  CPU access address / write data.
REQ-007 SHALL have ports cpu_gnt  output  1 (access performed this cycle), cpu_rvalid  output  1, cpu_rdata  output  DATA_W.
REQ-008 SHALL have port cpu_stall  output  1  CPU must hold pc/IR/state this cycle.
REQ-009 SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, same widths and meanings as the CPU set, for the debug/program loader.
REQ-010 SHALL have ports mem_addr  output  ADDR_W, mem_we  output  1, mem_wdata  output  DATA_W, mem_rdata  input  DATA_W (memory reads combinationally; writes on clk edge).

Function
REQ-011 SHALL implement FSM states IDLE, GNT_CPU, GNT_DBG.
REQ-012 SHALL, in IDLE, go to GNT_CPU if only cpu_req, GNT_DBG if only dbg_req, stay IDLE if neither.
REQ-013 SHALL, in IDLE with both requests, grant the port not granted last (round-robin via last_gnt bit).
REQ-014 SHALL return from GNT_CPU or GNT_DBG to IDLE unconditionally; max throughput one access per two cycles.
REQ-015 SHALL drive cpu_gnt=1 only in GNT_CPU, dbg_gnt=1 only in GNT_DBG, both decoded from state.
REQ-016 SHALL, in a GNT state, route that port's addr/we/wdata to mem_*; in IDLE drive mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 SHALL capture mem_rdata into the granted port's rdata register at the end of a GNT cycle with we=0, and assert that port's rvalid for exactly the following cycle.
REQ-018 SHALL hold rdata stable until the next read to the same port; rvalid=0 after writes.
REQ-019 SHALL require requesters to hold req/we/addr/wdata stable until gnt; req still high in the cycle after gnt is a new request.
REQ-020 SHALL ignore a request dropped before grant (no access, no rvalid).
REQ-021 SHALL drive cpu_stall = cpu_req & ~cpu_gnt, combinationally.
REQ-022 SHALL update last_gnt on every grant; bounds wait of either port to 4 cycles under round-robin.

Reset
REQ-023 SHALL, with rst high at a clock edge, force state=IDLE, last_gnt=DBG (CPU wins first tie), rvalids=0, rdata=0.
REQ-024 SHALL force mem_we=0 and both gnt=0 in any cycle where rst is high, including mid-access; an interrupted read produces no rvalid.

Configuration
REQ-025 SHALL support macro MEM_ARB_DBG_PRIO_EN: defined -> dbg always wins ties (fixed priority, CPU may starve); undefined -> round-robin per REQ-013.

Structure
REQ-026 SHALL place the state enum, port-ID encoding (CPU=0, DBG=1) and default ADDR_W/DATA_W constants in shared package mem_arb_pkg.
REQ-027 SHALL isolate tie-break logic in sub-module arb2_rr (req[1:0], last, grant one-hot).

Verification
REQ-028 SHALL cover single CPU read: cpu_req, addr=5, mem[5]=0xDEADBEEF -> cpu_gnt cycle 1, cpu_rvalid cycle 2 with cpu_rdata=0xDEADBEEF.
REQ-029 SHALL cover dbg write then CPU read: dbg writes 0x12345678 to addr 3, then cpu reads 3 -> cpu_rdata=0x12345678.
REQ-030 SHALL cover simultaneous requests, both held after reset -> grants CPU, DBG, CPU, DBG on cycles 1,3,5,7 (round-robin); DBG every time with MEM_ARB_DBG_PRIO_EN.
REQ-031 SHALL cover stall: dbg granted while cpu_req high -> cpu_stall=1 that cycle, 0 in cycle of cpu_gnt.
REQ-032 SHALL cover reset mid-read: rst high in GNT_CPU cycle -> mem_we=0, no cpu_rvalid, state IDLE next cycle.
REQ-033 SHALL cover dropped request: dbg_req pulsed one cycle while CPU granted -> no dbg_gnt, no dbg_rvalid.
